majority_oversampler: RTL

MAJORITY_OVERSAMPLER -- requirements
Module: majority_oversampler

---
 rtl/majority_oversampler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/majority_oversampler.sv
`default_nettype none
// ============================================================================
//  Module      : majority_oversampler
//  Description : Synchronizes a raw serial line, samples it once every DIV
//                enabled clock cycles, and groups the samples into triples.
//                For each completed triple it presents the three samples, a
//                registered majority vote and a disagreement flag with a
//                one-cycle valid strobe. It also keeps a saturating count of
//                disagreeing triples.
//  Ports       :
//    clk      in   system clock, rising edge
//    rst_n    in   asynchronous active-low reset
//    din      in   raw asynchronous serial line
//    en       in   sampling enable; low aborts any partial triple
//    clr_err  in   synchronous clear of err_cnt (wins over increment)
//    samp_a   out  oldest sample of the last completed triple
//    samp_b   out  middle sample of the last completed triple
//    samp_c   out  newest sample of the last completed triple
//    valid    out  one-cycle strobe: samp_*, vote, disagree just updated
//    vote     out  majority of samp_a/b/c
//    disagree out  samples of the triple not all equal
//    err_cnt  out  saturating count of disagreeing triples
//  Revision    : 1.0  initial release
// ============================================================================
module majority_oversampler #(
    parameter int DIV   = 4,   // enabled cycles between samples, 1..255
    parameter int ERR_W = 8    // width of err_cnt
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             clr_err,
    output logic             samp_a,
    output logic             samp_b,
    output logic             samp_c,
    output logic             valid,
    output logic             vote,
    output logic             disagree,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int               c_DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(DIV - 1);
    localparam logic [ERR_W-1:0] c_ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_A  = 2'd1,
        S_B  = 2'd2,
        S_C  = 2'd3
    } state_t;

    // Two-flop synchronizer; only r_din_s is ever sampled
    logic r_sync1;
    logic r_din_s;

    logic [c_DIV_W-1:0] r_div;
    state_t             r_state;
    logic               r_a;
    logic               r_b;

    logic               r_samp_a;
    logic               r_samp_b;
    logic               r_samp_c;
    logic               r_valid;
    logic               r_vote;
    logic               r_disagree;
    logic [ERR_W-1:0]   r_err_cnt;

    logic w_cap;
    logic w_fire;
    logic w_maj;
    logic w_dis;

    // A capture happens on the last count of each divider period
    assign w_cap  = en && (r_div == c_DIV_LAST);
    // Triple completes on the capture taken while waiting for the third slot
    assign w_fire = w_cap && (r_state == S_C);
    assign w_maj  = (r_a & r_b) | (r_a & r_din_s) | (r_b & r_din_s);
    assign w_dis  = !((r_a == r_b) && (r_b == r_din_s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_din_s <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_din_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_state    <= IDLE;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_samp_a   <= 1'b0;
            r_samp_b   <= 1'b0;
            r_samp_c   <= 1'b0;
            r_valid    <= 1'b0;
            r_vote     <= 1'b0;
            r_disagree <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!en) begin
                // Abort: partial samples are simply overwritten later
                r_div   <= '0;
                r_state <= IDLE;
            end else begin
                r_div <= w_cap ? '0 : r_div + 1'b1;
                case (r_state)
                    // With DIV=1 the very first enabled edge is already a
                    // capture, so IDLE must be able to take the first slot.
                    IDLE: begin
                        if (w_cap) begin
                            r_a     <= r_din_s;
                            r_state <= S_B;
                        end else begin
                            r_state <= S_A;
                        end
                    end
                    S_A: begin
                        if (w_cap) begin
                            r_a     <= r_din_s;
                            r_state <= S_B;
                        end
                    end
                    S_B: begin
                        if (w_cap) begin
                            r_b     <= r_din_s;
                            r_state <= S_C;
                        end
                    end
                    S_C: begin
                        if (w_cap) begin
                            r_samp_a   <= r_a;
                            r_samp_b   <= r_b;
                            r_samp_c   <= r_din_s;
                            r_vote     <= w_maj;
                            r_disagree <= w_dis;
                            r_valid    <= 1'b1;
                            r_state    <= S_A;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= '0;
        end else if (w_fire && w_dis && (r_err_cnt != c_ERR_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign samp_a   = r_samp_a;
    assign samp_b   = r_samp_b;
    assign samp_c   = r_samp_c;
    assign valid    = r_valid;
    assign vote     = r_vote;
    assign disagree = r_disagree;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire
